// File: rtl/rdm_req_sched.sv
// Packet-level round-robin scheduler sharing one RDM request stream among NUM_REQ requesters,
// with an order FIFO that steers each in-order RDM response back to its requester.
module rdm_req_sched #(
    parameter int NUM_REQ = 2,
    parameter int MAX_OUT = 8,
    parameter int DW      = 256,
    localparam int IW     = $clog2(NUM_REQ),
    localparam int OW     = $clog2(MAX_OUT + 1),
    localparam int KW     = DW / 8
) (
    input  logic                  clk_250,
    input  logic                  sys_rst,
    input  logic                  enable,

    input  logic [NUM_REQ*DW-1:0] s_tdata,
    input  logic [NUM_REQ*KW-1:0] s_tkeep,
    input  logic [NUM_REQ*64-1:0] s_tuser,
    input  logic [NUM_REQ-1:0]    s_tvalid,
    input  logic [NUM_REQ-1:0]    s_tlast,
    output logic [NUM_REQ-1:0]    s_tready,

    output logic [DW-1:0]         m_tdata,
    output logic [KW-1:0]         m_tkeep,
    output logic [63:0]           m_tuser,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,

    input  logic [DW-1:0]         r_s_tdata,
    input  logic [KW-1:0]         r_s_tkeep,
    input  logic [63:0]           r_s_tuser,
    input  logic                  r_s_tvalid,
    input  logic                  r_s_tlast,
    output logic                  r_s_tready,

    output logic [DW-1:0]         r_m_tdata,
    output logic [KW-1:0]         r_m_tkeep,
    output logic [63:0]           r_m_tuser,
    output logic [NUM_REQ-1:0]    r_m_tvalid,
    output logic [NUM_REQ-1:0]    r_m_tlast,
    input  logic [NUM_REQ-1:0]    r_m_tready,

    output logic [OW-1:0]         outstanding,
    output logic                  rsp_orphan
);

    localparam int PW = $clog2(MAX_OUT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FWD  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          orphan_q, orphan_d;
    logic [IW-1:0] order_mem_q [MAX_OUT];
    logic [IW-1:0] order_mem_d [MAX_OUT];

    logic [DW-1:0] s_data_a [NUM_REQ];
    logic [KW-1:0] s_keep_a [NUM_REQ];
    logic [63:0]   s_user_a [NUM_REQ];

    logic          arb_found;
    logic [IW-1:0] arb_winner;
    logic [IW:0]   cand;
    logic          fifo_empty;
    logic [IW-1:0] head;
    logic          push;
    logic          pop;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign s_data_a[i] = s_tdata[i*DW +: DW];
        assign s_keep_a[i] = s_tkeep[i*KW +: KW];
        assign s_user_a[i] = s_tuser[i*64 +: 64];
    end

    assign fifo_empty  = (outstanding_q == '0);
    assign head        = order_mem_q[rd_ptr_q];
    assign outstanding = outstanding_q;
    assign rsp_orphan  = orphan_q;

    // Round-robin search starting one past the last requester that completed a packet.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = last_grant_q;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!arb_found && s_tvalid[cand[IW-1:0]]) begin
                arb_found  = 1'b1;
                arb_winner = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        m_tdata  = s_data_a[grant_q];
        m_tkeep  = s_keep_a[grant_q];
        m_tuser  = s_user_a[grant_q];
        m_tlast  = s_tlast[grant_q];
        m_tvalid = 1'b0;
        s_tready = '0;
        if (!sys_rst && state_q == ST_FWD) begin
            m_tvalid          = s_tvalid[grant_q];
            s_tready[grant_q] = m_tready;
        end
        push = m_tvalid & m_tready & m_tlast;
    end

    // Responses come back in request order, so the FIFO head names the owner.
    always_comb begin
        r_m_tdata  = r_s_tdata;
        r_m_tkeep  = r_s_tkeep;
        r_m_tuser  = r_s_tuser;
        r_m_tvalid = '0;
        r_m_tlast  = '0;
        r_s_tready = 1'b0;
        if (!sys_rst && !fifo_empty) begin
            r_m_tvalid[head] = r_s_tvalid;
            r_m_tlast[head]  = r_s_tlast;
            r_s_tready       = r_m_tready[head];
        end
        pop = r_s_tvalid & r_s_tready & r_s_tlast;
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        order_mem_d   = order_mem_q;
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        outstanding_d = outstanding_q + OW'(push) - OW'(pop);
        orphan_d      = orphan_q | (fifo_empty & r_s_tvalid);
        if (push) begin
            order_mem_d[wr_ptr_q] = grant_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (enable && outstanding_q < OW'(MAX_OUT) && arb_found) begin
                    grant_d = arb_winner;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                if (push) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_250) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_grant_q  <= IW'(NUM_REQ - 1);
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            orphan_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            orphan_q      <= orphan_d;
        end
    end

    always_ff @(posedge clk_250) begin
        order_mem_q <= order_mem_d;
    end

endmodule

// File: tb/tb_rdm_req_sched.sv
// Randomized and directed bench for rdm_req_sched, checked every cycle against a
// queue-based model of the arbitration and response-routing rules.
module tb_rdm_req_sched;

    localparam int NR = 2;
    localparam int MO = 8;
    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int OW = $clog2(MO + 1);

    logic              clk_250 = 1'b0;
    logic              sys_rst;
    logic              enable;
    logic [NR*DW-1:0]  s_tdata;
    logic [NR*KW-1:0]  s_tkeep;
    logic [NR*64-1:0]  s_tuser;
    logic [NR-1:0]     s_tvalid;
    logic [NR-1:0]     s_tlast;
    logic [NR-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [63:0]       m_tuser;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [DW-1:0]     r_s_tdata;
    logic [KW-1:0]     r_s_tkeep;
    logic [63:0]       r_s_tuser;
    logic              r_s_tvalid;
    logic              r_s_tlast;
    logic              r_s_tready;
    logic [DW-1:0]     r_m_tdata;
    logic [KW-1:0]     r_m_tkeep;
    logic [63:0]       r_m_tuser;
    logic [NR-1:0]     r_m_tvalid;
    logic [NR-1:0]     r_m_tlast;
    logic [NR-1:0]     r_m_tready;
    logic [OW-1:0]     outstanding;
    logic              rsp_orphan;

    rdm_req_sched #(.NUM_REQ(NR), .MAX_OUT(MO), .DW(DW)) dut (
        .clk_250(clk_250), .sys_rst(sys_rst), .enable(enable),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
        .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .r_s_tdata(r_s_tdata), .r_s_tkeep(r_s_tkeep), .r_s_tuser(r_s_tuser),
        .r_s_tvalid(r_s_tvalid), .r_s_tlast(r_s_tlast), .r_s_tready(r_s_tready),
        .r_m_tdata(r_m_tdata), .r_m_tkeep(r_m_tkeep), .r_m_tuser(r_m_tuser),
        .r_m_tvalid(r_m_tvalid), .r_m_tlast(r_m_tlast), .r_m_tready(r_m_tready),
        .outstanding(outstanding), .rsp_orphan(rsp_orphan)
    );

    always #5 clk_250 = ~clk_250;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int req_pkts [NR][$];
    int beat [NR];
    int rsp_q [$];
    int rsp_beat;
    bit rnd_mode, rsp_auto, rsp_drive_en;
    int req_rate, rsp_rate;
    logic [NR-1:0] hs_req;
    logic          hs_rsp;

    int acc_src [$];
    int acc_cyc [$];
    int beat_src [$];
    int beat_cyc [$];
    int route_log [$];
    int rsp_done_cyc [$];

    bit mb_busy;
    int mb_grant;
    int mb_last;
    int mb_order [$];
    bit mb_orphan;

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: wait expired (cycle %0d)", name, cyc);
    endtask

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Model: expected outputs from the current inputs, then the state after the coming edge.
    always @(negedge clk_250) begin
        logic [NR-1:0] e_s_tready, e_r_m_tvalid, e_r_m_tlast;
        logic e_m_tvalid, e_r_s_tready;
        bit rq_done, rs_done;
        int g, h, pre_size;
        cyc++;
        hs_req = sys_rst ? '0 : (s_tvalid & s_tready);
        hs_rsp = !sys_rst && r_s_tvalid && r_s_tready;

        g = mb_grant;
        pre_size = mb_order.size();
        h = (pre_size > 0) ? mb_order[0] : 0;
        e_s_tready = '0; e_m_tvalid = 1'b0; e_r_s_tready = 1'b0;
        e_r_m_tvalid = '0; e_r_m_tlast = '0;
        if (!sys_rst) begin
            if (mb_busy) begin
                e_m_tvalid = s_tvalid[g];
                e_s_tready[g] = m_tready;
            end
            if (pre_size > 0) begin
                e_r_m_tvalid[h] = r_s_tvalid;
                e_r_m_tlast[h] = r_s_tlast;
                e_r_s_tready = r_m_tready[h];
            end
        end
        check_output("s_tready", s_tready, e_s_tready);
        check_output("m_tvalid", m_tvalid, e_m_tvalid);
        check_output("r_s_tready", r_s_tready, e_r_s_tready);
        check_output("r_m_tvalid", r_m_tvalid, e_r_m_tvalid);
        check_output("outstanding", outstanding, pre_size);
        check_output("rsp_orphan", rsp_orphan, mb_orphan);
        if (e_m_tvalid) begin
            check_output("m_tdata", m_tdata, s_tdata[g*DW +: DW]);
            check_output("m_tkeep", m_tkeep, s_tkeep[g*KW +: KW]);
            check_output("m_tuser", m_tuser, s_tuser[g*64 +: 64]);
            check_output("m_tlast", m_tlast, s_tlast[g]);
        end
        if (e_r_m_tvalid != '0) begin
            check_output("r_m_tdata", r_m_tdata, r_s_tdata);
            check_output("r_m_tkeep", r_m_tkeep, r_s_tkeep);
            check_output("r_m_tuser", r_m_tuser, r_s_tuser);
            check_output("r_m_tlast", r_m_tlast, e_r_m_tlast);
        end

        if (sys_rst) begin
            mb_busy = 1'b0;
            mb_last = NR - 1;
            mb_order.delete();
            mb_orphan = 1'b0;
        end else begin
            rq_done = mb_busy && s_tvalid[g] && m_tready && s_tlast[g];
            rs_done = pre_size > 0 && r_s_tvalid && r_m_tready[h] && r_s_tlast;
            if (mb_busy && s_tvalid[g] && m_tready) begin
                beat_src.push_back(g);
                beat_cyc.push_back(cyc);
            end
            if (pre_size > 0 && r_s_tvalid && r_m_tready[h]) route_log.push_back(h);
            if (pre_size == 0 && r_s_tvalid) mb_orphan = 1'b1;
            if (rs_done) begin
                void'(mb_order.pop_front());
                rsp_done_cyc.push_back(cyc);
            end
            if (rq_done) begin
                mb_order.push_back(g);
                acc_src.push_back(g);
                acc_cyc.push_back(cyc);
                mb_last = g;
                mb_busy = 1'b0;
            end else if (!mb_busy && enable && pre_size < MO && s_tvalid != '0) begin
                for (int k = 1; k <= NR; k++) begin
                    if (s_tvalid[(mb_last + k) % NR]) begin
                        mb_grant = (mb_last + k) % NR;
                        break;
                    end
                end
                mb_busy = 1'b1;
            end
        end
    end

    // Requester and RDM-side drivers; valid is held until the observed handshake.
    always @(posedge clk_250) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs_req[i] && req_pkts[i].size() > 0) begin
                if (rsp_auto && s_tlast[i]) rsp_q.push_back($urandom_range(3, 1));
                s_tvalid[i] = 1'b0;
                beat[i]++;
                if (beat[i] == req_pkts[i][0]) begin
                    void'(req_pkts[i].pop_front());
                    beat[i] = 0;
                end
            end
            if (!s_tvalid[i] && req_pkts[i].size() > 0 && $urandom_range(99) < req_rate) begin
                s_tdata[i*DW +: DW] = rand_dw();
                s_tkeep[i*KW +: KW] = $urandom;
                s_tuser[i*64 +: 64] = {$urandom, $urandom};
                s_tlast[i] = (beat[i] == req_pkts[i][0] - 1);
                s_tvalid[i] = 1'b1;
            end
        end
        if (hs_rsp && rsp_q.size() > 0) begin
            r_s_tvalid = 1'b0;
            rsp_beat++;
            if (rsp_beat == rsp_q[0]) begin
                void'(rsp_q.pop_front());
                rsp_beat = 0;
            end
        end
        if (rsp_drive_en && !r_s_tvalid && rsp_q.size() > 0 && $urandom_range(99) < rsp_rate) begin
            r_s_tdata = rand_dw();
            r_s_tkeep = $urandom;
            r_s_tuser = {$urandom, $urandom};
            r_s_tlast = (rsp_beat == rsp_q[0] - 1);
            r_s_tvalid = 1'b1;
        end
        if (rnd_mode) begin
            m_tready = ($urandom_range(99) < 75);
            r_m_tready = NR'($urandom);
            enable = ($urandom_range(99) < 90);
        end
    end

    task automatic sync();
        @(posedge clk_250);
        #2;
    endtask

    task automatic clear_bench();
        for (int i = 0; i < NR; i++) begin
            req_pkts[i].delete();
            beat[i] = 0;
        end
        s_tvalid = '0;
        r_s_tvalid = 1'b0;
        rsp_q.delete();
        rsp_beat = 0;
        acc_src.delete(); acc_cyc.delete();
        beat_src.delete(); beat_cyc.delete();
        route_log.delete(); rsp_done_cyc.delete();
    endtask

    task automatic apply_stimulus_reset();
        sync();
        sys_rst = 1'b1;
        clear_bench();
        rnd_mode = 1'b0; rsp_auto = 1'b0; rsp_drive_en = 1'b1;
        req_rate = 100; rsp_rate = 100;
        enable = 1'b1; m_tready = 1'b1; r_m_tready = '0;
        repeat (2) sync();
        sys_rst = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int limit, input string name);
        int c = 0;
        while (acc_src.size() < n && c < limit) begin
            sync();
            c++;
        end
        if (acc_src.size() < n) timeout_fail(name);
    endtask

    task automatic wait_rsp(input int n, input int limit, input string name);
        int c = 0;
        while (rsp_done_cyc.size() < n && c < limit) begin
            sync();
            c++;
        end
        if (rsp_done_cyc.size() < n) timeout_fail(name);
    endtask

    initial begin
        sys_rst = 1'b1; enable = 1'b0; m_tready = 1'b0; r_m_tready = '0;
        s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tvalid = '0; s_tlast = '0;
        r_s_tdata = '0; r_s_tkeep = '0; r_s_tuser = '0; r_s_tvalid = 1'b0; r_s_tlast = 1'b0;
        rnd_mode = 1'b0; rsp_auto = 1'b0; rsp_drive_en = 1'b1;
        req_rate = 100; rsp_rate = 100; rsp_beat = 0; hs_req = '0; hs_rsp = 1'b0;
        mb_busy = 1'b0; mb_grant = 0; mb_last = NR - 1; mb_orphan = 1'b0;

        apply_stimulus_reset();
        check_output("reset_outstanding", outstanding, 0);
        check_output("reset_orphan", rsp_orphan, 0);
        check_output("reset_m_tvalid", m_tvalid, 0);

        // Two packets contending from reset: req0 first, one bubble, then req1.
        req_pkts[0].push_back(3);
        req_pkts[1].push_back(2);
        wait_acc(2, 40, "two_pkt_wait");
        sync();
        check_output("two_pkt_beats", beat_src.size(), 5);
        if (beat_src.size() == 5) begin
            check_output("beat_order", {beat_src[0], beat_src[1], beat_src[2], beat_src[3], beat_src[4]},
                         {32'd0, 32'd0, 32'd0, 32'd1, 32'd1});
            check_output("in_packet_gap", beat_cyc[1] - beat_cyc[0], 1);
            check_output("bubble_gap", beat_cyc[3] - beat_cyc[2], 2);
        end
        check_output("two_pkt_outstanding", outstanding, 2);

        rsp_q.push_back(1);
        rsp_q.push_back(2);
        r_m_tready = '1;
        wait_rsp(2, 40, "two_rsp_wait");
        sync();
        check_output("route_count", route_log.size(), 3);
        if (route_log.size() == 3)
            check_output("route_order", {route_log[0], route_log[1], route_log[2]}, {32'd0, 32'd1, 32'd1});
        check_output("drain_outstanding", outstanding, 0);

        // Ten single-beat packets with no responses stop at the in-flight limit.
        apply_stimulus_reset();
        for (int i = 0; i < 10; i++) req_pkts[0].push_back(1);
        repeat (40) sync();
        check_output("limit_accepted", acc_src.size(), 8);
        check_output("limit_outstanding", outstanding, 8);
        check_output("limit_s_tready", s_tready[0], 0);
        rsp_q.push_back(1);
        r_m_tready = '1;
        wait_acc(9, 20, "refill_wait");
        if (acc_src.size() >= 9 && rsp_done_cyc.size() >= 1)
            check_output("refill_latency", acc_cyc[8] - rsp_done_cyc[0], 2);

        // Request and response tlast in the same cycle with three in flight.
        apply_stimulus_reset();
        req_pkts[0].push_back(1);
        req_pkts[0].push_back(1);
        req_pkts[1].push_back(1);
        wait_acc(3, 30, "three_wait");
        check_output("three_outstanding", outstanding, 3);
        if (acc_src.size() == 3)
            check_output("three_order", {acc_src[0], acc_src[1], acc_src[2]}, {32'd0, 32'd1, 32'd0});
        m_tready = 1'b0;
        req_pkts[1].push_back(1);
        rsp_q.push_back(1);
        repeat (4) sync();
        m_tready = 1'b1;
        r_m_tready = '1;
        sync();
        r_m_tready = '0;
        check_output("simul_outstanding", outstanding, 3);
        if (acc_cyc.size() == 4 && rsp_done_cyc.size() == 1)
            check_output("simul_same_cycle", acc_cyc[3], rsp_done_cyc[0]);
        else
            timeout_fail("simul_events");
        rsp_q.push_back(1);
        r_m_tready = '1;
        wait_rsp(2, 20, "head_advance_wait");
        if (route_log.size() >= 2) check_output("head_advance", route_log[1], 1);

        // Response with nothing outstanding is flagged and never accepted.
        apply_stimulus_reset();
        rsp_drive_en = 1'b0;
        r_s_tvalid = 1'b1;
        r_s_tlast = 1'b1;
        r_m_tready = '1;
        repeat (2) sync();
        check_output("orphan_ready", r_s_tready, 0);
        check_output("orphan_flag", rsp_orphan, 1);
        check_output("orphan_r_m_tvalid", r_m_tvalid, 0);
        r_s_tvalid = 1'b0;
        req_pkts[0].push_back(2);
        wait_acc(1, 20, "orphan_req_wait");
        check_output("orphan_sticky", rsp_orphan, 1);
        check_output("orphan_m_unaffected", outstanding, 1);

        // Reset during beat 2 of a 4-beat req1 packet.
        apply_stimulus_reset();
        req_pkts[1].push_back(4);
        begin
            int c = 0;
            while (beat_src.size() < 1 && c < 20) begin
                sync();
                c++;
            end
            if (beat_src.size() < 1) timeout_fail("midpkt_wait");
        end
        sys_rst = 1'b1;
        #1;
        check_output("midrst_m_tvalid", m_tvalid, 0);
        check_output("midrst_s_tready", s_tready, 0);
        check_output("midrst_r_s_tready", r_s_tready, 0);
        sync();
        check_output("midrst_outstanding", outstanding, 0);
        sync();
        clear_bench();
        sys_rst = 1'b0;
        req_pkts[0].push_back(1);
        req_pkts[1].push_back(1);
        wait_acc(2, 20, "post_rst_wait");
        if (acc_src.size() >= 1) check_output("post_rst_first", acc_src[0], 0);

        // Randomized traffic with random backpressure and response lengths.
        apply_stimulus_reset();
        rnd_mode = 1'b1;
        rsp_auto = 1'b1;
        req_rate = 40;
        rsp_rate = 60;
        for (int n = 0; n < 800; n++) begin
            sync();
            for (int i = 0; i < NR; i++)
                if (req_pkts[i].size() < 3 && $urandom_range(99) < 20)
                    req_pkts[i].push_back($urandom_range(4, 1));
        end
        check_output("rand_progress", acc_src.size() > 20, 1);
        rnd_mode = 1'b0;
        sync();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rdm_req_sched.md
Name: rdm_req_sched

Overview:
- Packet-level scheduler that shares the single 256-bit RDM request stream (PCIe-side AXI-Stream RX into the RDM BD) among NUM_REQ requesters.
- Limits in-flight requests to MAX_OUT.
- Records grant order and routes each RDM response packet (RDM TX stream) back to the requester that issued the matching request. RDM responses are returned in request order.
- Sits between the requester endpoints and the RDM BD RX/TX ports, all in the 250 MHz domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_OUT, 8, max requests accepted but not yet answered; also order-FIFO depth (power of 2, >=2).
- DW, 256, tdata width; tkeep is DW/8, tuser is 64.

Ports:
- clk_250  in  1  single clock for all logic.
- sys_rst  in  1  synchronous, active-high reset.
- enable  in  1  arbitration permitted (driver_ready equivalent).
- s_tdata/s_tkeep/s_tuser  in  NUM_REQ*DW / NUM_REQ*DW/8 / NUM_REQ*64  requester request streams, flattened, requester i at slice i.
- s_tvalid, s_tlast  in  NUM_REQ  per-requester valid/last.
- s_tready  out  NUM_REQ  per-requester ready.
- m_tdata/m_tkeep/m_tuser/m_tvalid/m_tlast  out  DW/DW/8/64/1/1  to RDM RX.
- m_tready  in  1  from RDM RX.
- r_s_tdata/r_s_tkeep/r_s_tuser/r_s_tvalid/r_s_tlast  in  DW/DW/8/64/1/1  from RDM TX.
- r_s_tready  out  1  to RDM TX.
- r_m_tdata/r_m_tkeep/r_m_tuser  out  DW/DW/8/64  response data, broadcast to all requesters.
- r_m_tvalid, r_m_tlast  out  NUM_REQ  per-requester response valid/last.
- r_m_tready  in  NUM_REQ  per-requester response ready.
- outstanding  out  clog2(MAX_OUT+1)  current in-flight count.
- rsp_orphan  out  1  sticky: response arrived with empty order FIFO.

Behaviour:
- Reset (sync, sys_rst=1 at posedge): state=IDLE, last_grant=NUM_REQ-1, outstanding=0, order FIFO empty, rsp_orphan=0.
- During and after reset: all s_tready, m_tvalid, r_s_tready and r_m_tvalid are 0.
- Reset mid-packet: the partial packet is abandoned (no tlast emitted) and the count is lost. The integrator resets RDM alongside.
- Request FSM:
  - IDLE: arbitrates when enable=1 AND outstanding+pending<MAX_OUT AND at least one s_tvalid is set.
  - Winner is round-robin: first set s_tvalid searching from last_grant+1 with wrap.
  - Winner is registered as grant; next state is FWD. This adds a one-cycle bubble per packet.
  - IDLE outputs: m_tvalid=0, all s_tready=0.
  - FWD: combinational passthrough from the granted requester: m_*=s_*[grant], m_tvalid=s_tvalid[grant], s_tready[grant]=m_tready, other s_tready=0.
  - FWD: on handshake (m_tvalid&m_tready&m_tlast), push grant into the order FIFO, set outstanding+=1 and last_grant=grant, return to IDLE.
  - Grant is locked until tlast; enable deassertion does not preempt a packet in FWD.
- Response routing:
  - head = order FIFO head.
  - FIFO empty: r_s_tready=0 and all r_m_tvalid=0. If r_s_tvalid=1, set rsp_orphan=1 (sticky until reset).
  - FIFO not empty: r_m_tvalid[head]=r_s_tvalid, r_m_tlast[head]=r_s_tlast, r_s_tready=r_m_tready[head]; all other r_m_tvalid=0.
  - Response data, keep and user are broadcast to all requesters.
  - On r_s handshake with tlast: pop the FIFO and set outstanding-=1.
- Simultaneous request tlast and response tlast in the same cycle: outstanding unchanged; push and pop both occur.
- A pop on a 1-entry FIFO with a same-cycle push is legal.
- The FIFO never overflows because the arbitration gate guarantees outstanding<MAX_OUT before grant.
- Latency: first beat is visible on m_* 1 cycle after s_tvalid rises while IDLE. Response path is zero-latency combinational.
- Back-to-back multi-beat packets: one bubble cycle between packets. No gaps within a packet other than those from valid/ready.

Test Plan:
1. Reset, enable=1, req0 sends a 3-beat packet and req1 a 2-beat packet, both valid at cycle 0 -> m carries req0 beats 1-3, 1 bubble, then req1 beats 1-2; outstanding=2.
2. Then RDM returns a 1-beat response followed by a 2-beat response -> the first appears only on r_m_tvalid[0], the second only on r_m_tvalid[1]; outstanding returns to 0.
3. MAX_OUT=8, req0 streams 10 single-beat packets with no responses -> exactly 8 accepted, s_tready[0]=0 thereafter; one response tlast -> 9th packet accepted within 2 cycles.
4. Request tlast and response tlast in the same cycle with outstanding=3 -> outstanding stays 3; FIFO head advances correctly (next response routes to the next queued id).
5. r_s_tvalid=1 after reset with no requests issued -> r_s_tready=0, rsp_orphan=1 and held; m stream unaffected.
6. sys_rst asserted during beat 2 of a 4-beat req1 packet -> next cycle all valids/readys=0, outstanding=0; after release req0 wins first arbitration.
